// File: rtl/rv_fetch_queue_pkg.sv
// Shared fetch types: decode-facing bus bundle and RVC helpers.
// Imported by the fetch queue and its word FIFO.
package rv_fetch_queue_pkg;

    localparam int FQ_DEPTH = 4;
    localparam int PTR_W = $clog2(FQ_DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        ready;
    } fetch_bus_t;

    function automatic logic is_rvc(logic [1:0] op);
        return op != 2'b11;
    endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// Prefetch word storage with wrapping pointers and occupancy count.
// Head and the low half of head+1 are read combinationally.
module rv_fetch_fifo
    import rv_fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [31:0]              i_data,
    output logic [31:0]              o_head,
    output logic [15:0]              o_next_lo,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_nxt;
    logic [PW:0]   count;

    always_ff @(posedge i_clk) begin
        if (i_push)
            mem[wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (i_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, i_push}
                           - {{PW{1'b0}}, i_pop};
        end
    end

    always_comb begin
        rd_nxt    = rd_ptr + 1'b1;
        o_head    = mem[rd_ptr];
        o_next_lo = mem[rd_nxt][15:0];
        o_count   = count;
    end

endmodule

// File: rtl/rv_fetch_queue.sv
// Fetch unit: prefetches words ahead of decode and aligns
// 16/32-bit instructions out of the queued halfwords.
module rv_fetch_queue
    import rv_fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = FQ_DEPTH,
    parameter bit          EXT_C      = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_pc_target,
    input  logic        i_pc_select,
    input  logic        i_decode_ready,
    input  logic [31:0] i_instruction,
    input  logic        i_ack,
    output logic [31:0] o_addr,
    output logic        o_cyc,
    output fetch_bus_t  o_bus
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW+1:0] ONE = (PW+2)'(1);

    logic [31:0]   fetch_pc;
    logic [31:0]   head_pc;
    logic          h;
    logic [PW:0]   count;
    logic [31:0]   w0;
    logic [15:0]   w1_lo;
    logic [15:0]   hw;
    logic [PW+1:0] avail;
    logic          rvc;
    logic          ready;
    logic          push;
    logic          fire;
    logic          free;
    logic [31:0]   inst;

    rv_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_flush   (i_pc_select),
        .i_push    (push),
        .i_pop     (free),
        .i_data    (i_instruction),
        .o_head    (w0),
        .o_next_lo (w1_lo),
        .o_count   (count)
    );

    // count==DEPTH is exactly the MSB being set (DEPTH is a power of 2)
    always_comb begin
        hw    = h ? w0[31:16] : w0[15:0];
        rvc   = EXT_C && is_rvc(hw[1:0]);
        avail = {count, 1'b0} - {{(PW+1){1'b0}}, h};
        ready = !i_reset && !i_pc_select && (count != '0)
                && ((|avail[PW+1:1]) || (avail == ONE && rvc));
        o_cyc = !i_reset && !i_pc_select && !count[PW];
        push  = o_cyc && i_ack;
        fire  = ready && i_decode_ready;
        free  = fire && (!rvc || h);
        if (rvc)
            inst = {16'h0, hw};
        else if (h)
            inst = {w1_lo, w0[31:16]};
        else
            inst = w0;
        o_addr            = fetch_pc;
        o_bus.pc          = head_pc;
        o_bus.instruction = ready ? inst : 32'h0;
        o_bus.ready       = ready;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc <= RESET_ADDR;
            head_pc  <= RESET_ADDR;
            h        <= 1'b0;
        end else if (i_pc_select) begin
            fetch_pc <= {i_pc_target[31:2], 2'b00};
            head_pc  <= i_pc_target;
            h        <= EXT_C && i_pc_target[1];
        end else begin
            if (push)
                fetch_pc <= fetch_pc + 32'd4;
            if (fire) begin
                head_pc <= head_pc + (rvc ? 32'd2 : 32'd4);
                if (rvc)
                    h <= ~h;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && i_pc_select && !EXT_C)
            assert (!i_pc_target[1]);
    end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// Randomised bench: bus and decode are driven at random and checked
// against a program-order model of fetch address and instruction stream.
module tb_rv_fetch_queue;
    import rv_fetch_queue_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0020;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] tgt;
    logic        sel;
    logic        dready;
    logic [31:0] rdata;
    logic        ack;
    logic [31:0] addr;
    logic        cyc;
    fetch_bus_t  bus;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [64];
    logic [31:0] m_fpc;
    logic [31:0] m_hpc;
    logic        post_rst;

    rv_fetch_queue #(
        .RESET_ADDR (RST_PC),
        .DEPTH      (DEPTH),
        .EXT_C      (1'b1)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_pc_target    (tgt),
        .i_pc_select    (sel),
        .i_decode_ready (dready),
        .i_instruction  (rdata),
        .i_ack          (ack),
        .o_addr         (addr),
        .o_cyc          (cyc),
        .o_bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    initial begin
        int cnt;
        int avail;
        logic c16;
        logic e_cyc;
        logic e_rdy;
        logic [31:0] e_ins;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if ($urandom_range(0, 1) == 1) mem[i][1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) mem[i][17:16] = 2'b11;
        end
        for (int i = 0; i < 4; i++) mem[i] = 32'h0000_0013;
        m_fpc = RST_PC;
        m_hpc = RST_PC;
        post_rst = 1'b0;
        rst = 1'b1; sel = 1'b0; tgt = '0;
        dready = 1'b0; ack = 1'b0; rdata = '0;

        for (int cy = 0; cy < 4000; cy++) begin
            @(negedge clk);
            rst = (cy < 2) || (cy > 600 && $urandom_range(0, 99) == 0);
            if (cy < 40) begin
                ack = 1'b1; dready = 1'b1; sel = 1'b0;
            end else if (cy < 300) begin
                ack = $urandom_range(0, 9) < 7;
                dready = $urandom_range(0, 3) == 0;
                sel = 1'b0;
            end else begin
                ack = $urandom_range(0, 1) == 1;
                dready = $urandom_range(0, 2) != 0;
                sel = $urandom_range(0, 99) < 6;
            end
            if ($urandom_range(0, 3) == 0)
                tgt = 32'hFFFF_FFF0 + 32'(2 * $urandom_range(0, 7));
            else
                tgt = 32'(2 * $urandom_range(0, 127));
            rdata = mem[m_fpc[7:2]];
            #1;
            if (cy > 0) begin
                cnt = int'((m_fpc - {m_hpc[31:2], 2'b00}) >> 2);
                avail = 2 * cnt - int'(m_hpc[1]);
                c16 = hw_at(m_hpc)[1:0] != 2'b11;
                e_cyc = !rst && !sel && cnt < DEPTH;
                e_rdy = !rst && !sel && cnt > 0
                        && (avail >= 2 || (avail == 1 && c16));
                e_ins = c16 ? {16'h0, hw_at(m_hpc)}
                            : {hw_at(m_hpc + 32'd2), hw_at(m_hpc)};
                check("o_cyc", 32'(cyc), 32'(e_cyc));
                if (e_cyc) check("o_addr", addr, m_fpc);
                check("ready", 32'(bus.ready), 32'(e_rdy));
                if (e_rdy && bus.ready) begin
                    check("pc", bus.pc, m_hpc);
                    check("instr", bus.instruction, e_ins);
                end
                if (post_rst) begin
                    check("rst_pc", bus.pc, RST_PC);
                    check("rst_instr", bus.instruction, 32'h0);
                end
                if (rst) begin
                    m_fpc = RST_PC;
                    m_hpc = RST_PC;
                end else if (sel) begin
                    m_fpc = {tgt[31:2], 2'b00};
                    m_hpc = tgt;
                end else begin
                    if (e_cyc && ack) m_fpc = m_fpc + 32'd4;
                    if (e_rdy && dready)
                        m_hpc = m_hpc + (c16 ? 32'd2 : 32'd4);
                end
            end
            post_rst = rst;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
